// File: rtl/dma_pkg.sv
// Shared types for the DMA peripheral request block: FSM encoding,
// synchronized control bundle and signal-polarity helpers.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_GAP,
        ST_DONE
    } dma_state_e;

    // Controller-side strobes after conversion to active-high.
    typedef struct packed {
        logic ack;
        logic rd;
        logic eop;
    } dma_ctl_t;

    localparam int         SYNC_STAGES = 2;
    localparam logic [7:0] DB_IDLE     = 8'h00;

    // Converts between the internal active-high level and a pin level.
    function automatic logic pol_apply(input logic level, input logic active_low);
        return level ^ active_low;
    endfunction

endpackage

// File: rtl/dma_byte_fifo.sv
// Byte FIFO with occupancy count; DEPTH must be a power of two >= 2 so the
// pointers wrap naturally.
module dma_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                         gclk,
    input  logic                         grst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [7:0]                   din,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [7:0]                   head,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge gclk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dma_periph_req.sv
// Peripheral-side DMA request/acknowledge handshake with a byte FIFO.
// Define DMA_PERIPH_EOP_EN to honour EOP_N (sticky done flag, DONE state).
module dma_periph_req
    import dma_pkg::*;
#(
    parameter bit DREQ_ACTIVE_LOW = 1'b0,
    parameter bit DACK_ACTIVE_LOW = 1'b1,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] dev_data,
    input  logic       dev_valid,
    output logic       dev_ready,
    input  logic       demand_mode,
    input  logic       DACK,
    input  logic       IOR_N,
    input  logic       EOP_N,
    input  logic       done_clr,
    output logic       DREQ,
    output logic [7:0] DB,
    output logic       db_oe,
    output logic       done
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    dma_state_e                  state, state_nx;
    dma_ctl_t                    ctl_raw;
    dma_ctl_t [SYNC_STAGES-1:0]  sync_pipe;
    logic                        ack, rd, eop, rd_prev;
    logic                        dreq_q, dreq_nx;
    logic                        mode_q;
    logic                        done_q, done_set;
    logic                        eop_term;
    logic                        pop_evt, pop_en, push_acc;
    logic [CW-1:0]               count, count_after;
    logic [7:0]                  head;
    logic                        full, empty;

    assign ctl_raw.ack = pol_apply(DACK, DACK_ACTIVE_LOW);
    assign ctl_raw.rd  = ~IOR_N;
`ifdef DMA_PERIPH_EOP_EN
    assign ctl_raw.eop = ~EOP_N;
`else
    assign ctl_raw.eop = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_pipe <= '0;
            rd_prev   <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], ctl_raw};
            rd_prev   <= rd;
        end
    end

    assign ack = sync_pipe[SYNC_STAGES-1].ack;
    assign rd  = sync_pipe[SYNC_STAGES-1].rd;
    assign eop = sync_pipe[SYNC_STAGES-1].eop;

    // A byte leaves on the trailing edge of the read strobe, only mid-transfer.
    assign pop_evt     = (state == ST_XFER) && ack && rd_prev && !rd;
    assign pop_en      = pop_evt && !empty;
    assign dev_ready   = !full || pop_en;
    assign push_acc    = dev_valid && dev_ready;
    assign count_after = count - CW'(1) + CW'(push_acc);

    dma_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .gclk   (CLK),
        .grst_n (RESET_N),
        .push   (push_acc),
        .pop    (pop_en),
        .din    (dev_data),
        .count  (count),
        .head   (head),
        .full   (full),
        .empty  (empty)
    );

    assign db_oe = ack && rd;
    assign DB    = (db_oe && !empty) ? head : DB_IDLE;
    assign DREQ  = pol_apply(dreq_q, DREQ_ACTIVE_LOW);
    assign done  = done_q;

`ifdef DMA_PERIPH_EOP_EN
    logic eop_now, eop_seen;

    // EOP may release together with IOR_N, so remember it until the pop.
    assign eop_now  = (state == ST_XFER) && ack && eop;
    assign eop_term = eop_now || eop_seen;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            eop_seen <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            eop_seen <= (state == ST_XFER) && !pop_en && eop_term;
            done_q   <= done_set || (done_q && !done_clr);
        end
    end
`else
    logic eop_unused;

    assign eop_unused = EOP_N ^ eop;
    assign eop_term   = 1'b0;
    assign done_q     = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= ST_IDLE;
            dreq_q <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            state  <= state_nx;
            dreq_q <= dreq_nx;
            if (state == ST_IDLE) mode_q <= demand_mode;
        end
    end

    always_comb begin
        state_nx = state;
        dreq_nx  = 1'b0;
        done_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty && !done_q) begin
                    state_nx = ST_REQ;
                    dreq_nx  = 1'b1;
                end
            end
            ST_REQ: begin
                dreq_nx = 1'b1;
                if (ack) begin
                    state_nx = ST_XFER;
                    dreq_nx  = mode_q;
                end
            end
            ST_XFER: begin
                dreq_nx = mode_q && !eop_term;
                if (pop_en) begin
                    if (eop_term) begin
                        state_nx = ST_DONE;
                        done_set = 1'b1;
                        dreq_nx  = 1'b0;
                    end else if (!mode_q || count_after == '0) begin
                        state_nx = ST_GAP;
                        dreq_nx  = 1'b0;
                    end
                end
            end
            ST_GAP: begin
                if (!ack) state_nx = ST_IDLE;
            end
            ST_DONE: begin
                if (done_clr) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule
